// File: rtl/branch_predictor.sv
// branch_predictor
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// After reset an INIT sweep invalidates every entry (one per cycle); the table
// then runs until the next reset. Lookups have one cycle of latency and freeze
// while i_stall is high. Updates from execute are applied whenever the table is
// ready, independent of i_stall.
//
// Optional feature: define BP_STATS_EN to build saturating counters of
// resolved branches and mispredictions; without it both outputs are tied to 0.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_stall                 holds the prediction outputs, blocks lookups
//   i_lookup_valid/_pc      lookup request
//   o_pred_valid/_taken/_tgt prediction (target is 0 when not taken)
//   i_update_*              resolved branch from execute
//   o_ready                 INIT sweep complete, traffic accepted
//   o_branch_count          resolved branches (BP_STATS_EN)
//   o_mispredict_count      mispredictions (BP_STATS_EN)
module branch_predictor #(
  parameter int PC_W  = 16,
  parameter int IDX_W = 6,
  parameter int CNT_W = 19
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_lookup_valid,
  input  logic [PC_W-1:0]  i_lookup_pc,
  output logic             o_pred_valid,
  output logic             o_pred_taken,
  output logic [PC_W-1:0]  o_pred_tgt,
  input  logic             i_update_valid,
  input  logic [PC_W-1:0]  i_update_pc,
  input  logic             i_update_taken,
  input  logic [PC_W-1:0]  i_update_tgt,
  input  logic             i_update_mispredict,
  output logic             o_ready,
  output logic [CNT_W-1:0] o_branch_count,
  output logic [CNT_W-1:0] o_mispredict_count
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = PC_W - IDX_W - 1;

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    if (c == 2'b11) sat_inc2 = 2'b11;
    else            sat_inc2 = c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] c);
    if (c == 2'b00) sat_dec2 = 2'b00;
    else            sat_dec2 = c - 2'b01;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [IDX_W:0]   r_sweep_idx, w_sweep_idx_nxt;
  logic             r_ready;
  logic             w_sweep_done, w_sweep_write;

  logic             r_valid [ENTRIES];
  logic [TAG_W-1:0] r_tag   [ENTRIES];
  logic [1:0]       r_cnt   [ENTRIES];
  logic [PC_W-1:0]  r_tgt   [ENTRIES];

  logic             r_pred_valid, r_pred_taken;
  logic [PC_W-1:0]  r_pred_tgt;

  logic [IDX_W-1:0] w_lu_idx, w_up_idx;
  logic [TAG_W-1:0] w_lu_tag, w_up_tag;
  logic             w_lu_acc, w_lu_hit_taken, w_up_do, w_up_hit;
  logic             w_unused;

  // The extra MSB of the sweep index flags that every entry has been written.
  assign w_sweep_done  = r_sweep_idx[IDX_W];
  assign w_sweep_write = (r_state == ST_INIT) && !w_sweep_done;

  assign w_lu_idx = i_lookup_pc[IDX_W:1];
  assign w_lu_tag = i_lookup_pc[PC_W-1:IDX_W+1];
  assign w_up_idx = i_update_pc[IDX_W:1];
  assign w_up_tag = i_update_pc[PC_W-1:IDX_W+1];

  assign w_lu_acc       = i_lookup_valid && r_ready && !i_stall;
  assign w_lu_hit_taken = r_valid[w_lu_idx] && (r_tag[w_lu_idx] == w_lu_tag) && r_cnt[w_lu_idx][1];
  assign w_up_do        = i_update_valid && r_ready;
  assign w_up_hit       = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  // pc[0] is not part of index or tag; mispredict only feeds the optional stats.
  assign w_unused = ^{i_lookup_pc[0], i_update_pc[0], i_update_mispredict};

  // Next-state logic for the INIT sweep / RUN controller.
  always_comb begin
    w_state_nxt     = r_state;
    w_sweep_idx_nxt = r_sweep_idx;
    case (r_state)
      ST_INIT: begin
        if (w_sweep_done) w_state_nxt = ST_RUN;
        else              w_sweep_idx_nxt = r_sweep_idx + {{IDX_W{1'b0}}, 1'b1};
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Controller state, sweep index and the registered ready flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_INIT;
      r_sweep_idx <= {(IDX_W+1){1'b0}};
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_idx_nxt;
      r_ready     <= (w_state_nxt == ST_RUN);
    end
  end

  // Table storage: INIT sweep writes, otherwise resolved-branch updates.
  // Lookups read the same arrays combinationally, so a same-cycle update
  // to the lookup index is not visible until the next cycle.
  always_ff @(posedge i_clk) begin
    if (w_sweep_write) begin
      r_valid[r_sweep_idx[IDX_W-1:0]] <= 1'b0;
      r_cnt[r_sweep_idx[IDX_W-1:0]]   <= 2'b01;
    end else if (w_up_do) begin
      if (w_up_hit) begin
        if (i_update_taken) begin
          r_cnt[w_up_idx] <= sat_inc2(r_cnt[w_up_idx]);
          r_tgt[w_up_idx] <= i_update_tgt;
        end else begin
          r_cnt[w_up_idx] <= sat_dec2(r_cnt[w_up_idx]);
        end
      end else if (i_update_taken) begin
        r_valid[w_up_idx] <= 1'b1;
        r_tag[w_up_idx]   <= w_up_tag;
        r_cnt[w_up_idx]   <= 2'b10;
        r_tgt[w_up_idx]   <= i_update_tgt;
      end
    end
  end

  // Prediction register: frozen during stall, cleared when nothing is looked up.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_tgt   <= {PC_W{1'b0}};
    end else if (!i_stall) begin
      r_pred_valid <= w_lu_acc;
      r_pred_taken <= w_lu_acc && w_lu_hit_taken;
      if (w_lu_acc && w_lu_hit_taken) r_pred_tgt <= r_tgt[w_lu_idx];
      else                            r_pred_tgt <= {PC_W{1'b0}};
    end
  end

  assign o_ready      = r_ready;
  assign o_pred_valid = r_pred_valid;
  assign o_pred_taken = r_pred_taken;
  assign o_pred_tgt   = r_pred_tgt;

`ifdef BP_STATS_EN
  logic [CNT_W-1:0] r_branch_count, r_mispredict_count;

  // Saturating statistics counters, stepped by every processed update.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_branch_count     <= {CNT_W{1'b0}};
      r_mispredict_count <= {CNT_W{1'b0}};
    end else if (w_up_do) begin
      if (r_branch_count != {CNT_W{1'b1}})
        r_branch_count <= r_branch_count + {{(CNT_W-1){1'b0}}, 1'b1};
      if (i_update_mispredict && (r_mispredict_count != {CNT_W{1'b1}}))
        r_mispredict_count <= r_mispredict_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_branch_count     = r_branch_count;
  assign o_mispredict_count = r_mispredict_count;
`else
  assign o_branch_count     = {CNT_W{1'b0}};
  assign o_mispredict_count = {CNT_W{1'b0}};
`endif

endmodule
